neo_data_decoder: RTL and testbench
===================================

// Module: neo_data_decoder
// PURPOSE
//  Consumes the single-wire neo_data stream from NeoPixelStrandController and decodes it
//  back into 24-bit GRB pixel words and frame boundaries, as a WS2812-style receiver would.
//  Sits downstream of the strand controller, in place of the physical strand. It gives the
//  bench and on-board debug a cycle-accurate checker of what was actually sent.
// PARAMETERS
//  ONE_THRESH   27    high-pulse length (clocks) at or above which a bit decodes as 1
//  MIN_HIGH     8     high pulses shorter than this are glitches
//  MAX_HIGH     60    high pulses longer than this are stuck-high errors
//  RESET_CYCLES 2500  consecutive low clocks that mark latch/end-of-frame (50us @ 50MHz)
//  NUM_PIXELS   5     pixels per frame on the strand (1..8)
// PORTS
//  clock         in   1   system clock
//  reset         in   1   synchronous, active-high reset
//  neo_data      in   1   serial stream from the strand controller (on-chip, same clock domain)
//  pixel_grb     out  24  last decoded word: [23:16]=G, [15:8]=R, [7:0]=B, first bit = MSB of G
//  pixel_valid   out  1   one-cycle strobe: pixel_grb/pixel_num are newly valid
//  pixel_num     out  3   index of decoded pixel within the frame (0 = first sent)
//  frame_done    out  1   one-cycle strobe on latch detection
//  frame_pixels  out  4   complete pixels in the frame just latched; valid with frame_done
//  glitch_err    out  1   one-cycle strobe: high pulse < MIN_HIGH or > MAX_HIGH
//  partial_err   out  1   one-cycle strobe with frame_done when 1..23 bits were left over
//  overrun_err   out  1   one-cycle strobe when pixel NUM_PIXELS+1 completes in one frame
// BEHAVIOUR
//  - neo_data is registered once (d_q); all edge detection uses d_q and its previous value.
//  - Reset (any cycle, including mid-pixel) clears every output, counter and shift register
//    to 0 and forces the FSM to WAIT_IDLE.
//  - Outputs are registered. Every strobe is high for exactly one clock.
//  - Strobe latency: a strobe is visible 2 clock edges after the edge that first samples
//    neo_data in the triggering level.
//  - FSM:
//    WAIT_IDLE: low_cnt counts consecutive low d_q and clears on any high.
//      When low_cnt reaches RESET_CYCLES -> IDLE. Emits no frame_done.
//    IDLE: rising edge -> HIGH with high_cnt=1.
//    HIGH: high_cnt++, saturating at MAX_HIGH+1.
//      If high_cnt > MAX_HIGH: glitch_err; drop the frame -> WAIT_IDLE.
//      On falling edge with high_cnt < MIN_HIGH: glitch_err; drop the frame -> WAIT_IDLE.
//      On any other falling edge: bit = (high_cnt >= ONE_THRESH); shift it into sreg[0]
//        (MSB-first stream); bit_cnt++; then -> LOW with low_cnt=1.
//      If bit_cnt reaches 24:
//        pixel_cnt < NUM_PIXELS: pixel_valid=1, pixel_grb=sreg, pixel_num=pixel_cnt,
//          pixel_cnt++.
//        pixel_cnt = NUM_PIXELS: overrun_err=1, no pixel_valid, pixel_cnt holds.
//        In both cases bit_cnt -> 0.
//    LOW: low_cnt++. Rising edge -> HIGH with high_cnt=1.
//      When low_cnt reaches RESET_CYCLES: frame_done=1, frame_pixels=pixel_cnt,
//        partial_err=(bit_cnt!=0); clear bit_cnt, pixel_cnt, sreg -> IDLE.
//  - Dropping a frame clears bit_cnt, pixel_cnt and sreg, and emits no frame_done.
//  - pixel_grb, pixel_num and frame_pixels hold their value between strobes.
//  - Counter widths: high_cnt = $clog2(MAX_HIGH+2), low_cnt = $clog2(RESET_CYCLES+1),
//    bit_cnt = 5 bits, pixel_cnt = 4 bits. No counter ever wraps.
//  - Simultaneous events:
//    24th bit ending with overrun -> overrun_err only.
//    Reset has priority over every event.
// TESTING
//  Bit timing for all tests: T0H=18, T1H=35, bit period=62 clocks.
//  1 reset, 2500 low, pixel 0x102030, 2500 low -> pixel_valid once (grb=0x102030, num=0);
//    frame_done with frame_pixels=1; no errors.
//  2 frame FF0000,00FF00,0000FF,FFFFFF,000000 then latch -> 5 valids, num 0..4, words match;
//    frame_pixels=5.
//  3 six pixels then latch -> 5 valids; overrun_err on 6th; frame_pixels=5; partial_err=0.
//  4a 4-clock high pulse mid-pixel -> glitch_err; no pixel_valid; no frame_done;
//     decodes again after 2500 low.
//  4b 70-clock high pulse -> glitch_err; no pixel_valid; no frame_done;
//     decodes again after 2500 low.
//  5 12 bits then 2500 low -> frame_done, frame_pixels=0, partial_err=1.
//  6 reset at bit 10 of pixel 2 -> all outputs 0 next cycle; a full 5-pixel frame sent after
//    2500 low decodes cleanly.

Source files
------------

// File: rtl/neo_data_decoder.sv
// WS2812-style receiver: turns the strand controller's single-wire stream back into
// 24-bit GRB pixel words, frame latches and one-cycle error strobes.
module neo_data_decoder #(
  parameter int ONE_THRESH   = 27,
  parameter int MIN_HIGH     = 8,
  parameter int MAX_HIGH     = 60,
  parameter int RESET_CYCLES = 2500,
  parameter int NUM_PIXELS   = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        neo_data,
  output logic [23:0] pixel_grb,
  output logic        pixel_valid,
  output logic [2:0]  pixel_num,
  output logic        frame_done,
  output logic [3:0]  frame_pixels,
  output logic        glitch_err,
  output logic        partial_err,
  output logic        overrun_err
);

  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_CYCLES + 1);

  localparam logic [HW-1:0] ONE_T    = HW'(ONE_THRESH);
  localparam logic [HW-1:0] MIN_T    = HW'(MIN_HIGH);
  localparam logic [HW-1:0] MAX_T    = HW'(MAX_HIGH);
  localparam logic [HW-1:0] HIGH_SAT = HW'(MAX_HIGH + 1);
  localparam logic [LW-1:0] LOW_LAST = LW'(RESET_CYCLES - 1);
  localparam logic [LW-1:0] LOW_FULL = LW'(RESET_CYCLES);
  localparam logic [3:0]    NUM_PX   = 4'(NUM_PIXELS);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, HIGH, LOW} state_t;

  state_t        r_state;
  logic          r_dq;
  logic          r_dqPrev;
  logic [HW-1:0] r_highCnt;
  logic [LW-1:0] r_lowCnt;
  logic [4:0]    r_bitCnt;
  logic [3:0]    r_pixelCnt;
  logic [23:0]   r_sreg;

  logic          w_rise;
  logic          w_bit;
  logic [23:0]   w_nextSreg;

  assign w_rise     = r_dq & ~r_dqPrev;
  assign w_bit      = (r_highCnt >= ONE_T);
  assign w_nextSreg = {r_sreg[22:0], w_bit};

  // Input register, pulse-width counters, decode FSM and registered outputs in one process
  // so every strobe is a plain one-cycle register pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= WAIT_IDLE;
      r_dq         <= 1'b0;
      r_dqPrev     <= 1'b0;
      r_highCnt    <= '0;
      r_lowCnt     <= '0;
      r_bitCnt     <= '0;
      r_pixelCnt   <= '0;
      r_sreg       <= '0;
      pixel_grb    <= '0;
      pixel_valid  <= 1'b0;
      pixel_num    <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      glitch_err   <= 1'b0;
      partial_err  <= 1'b0;
      overrun_err  <= 1'b0;
    end else begin
      r_dq        <= neo_data;
      r_dqPrev    <= r_dq;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      glitch_err  <= 1'b0;
      partial_err <= 1'b0;
      overrun_err <= 1'b0;

      case (r_state)
        WAIT_IDLE: begin
          if (r_dq) begin
            r_lowCnt <= '0;
          end else if (r_lowCnt == LOW_LAST) begin
            r_lowCnt <= LOW_FULL;
            r_state  <= IDLE;
          end else begin
            r_lowCnt <= r_lowCnt + 1'b1;
          end
        end

        IDLE: begin
          if (w_rise) begin
            r_highCnt <= HW'(1);
            r_state   <= HIGH;
          end
        end

        HIGH: begin
          if (r_dq) begin
            // This cycle would push the count past MAX_HIGH: stuck-high, drop the frame.
            if (r_highCnt >= MAX_T) begin
              r_highCnt  <= HIGH_SAT;
              glitch_err <= 1'b1;
              r_bitCnt   <= '0;
              r_pixelCnt <= '0;
              r_sreg     <= '0;
              r_lowCnt   <= '0;
              r_state    <= WAIT_IDLE;
            end else begin
              r_highCnt <= r_highCnt + 1'b1;
            end
          end else if (r_highCnt < MIN_T) begin
            glitch_err <= 1'b1;
            r_bitCnt   <= '0;
            r_pixelCnt <= '0;
            r_sreg     <= '0;
            r_lowCnt   <= '0;
            r_state    <= WAIT_IDLE;
          end else begin
            r_sreg   <= w_nextSreg;
            r_lowCnt <= LW'(1);
            r_state  <= LOW;
            if (r_bitCnt == 5'd23) begin
              r_bitCnt <= '0;
              if (r_pixelCnt < NUM_PX) begin
                pixel_valid <= 1'b1;
                pixel_grb   <= w_nextSreg;
                pixel_num   <= r_pixelCnt[2:0];
                r_pixelCnt  <= r_pixelCnt + 1'b1;
              end else begin
                overrun_err <= 1'b1;
              end
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end
        end

        LOW: begin
          if (w_rise) begin
            r_highCnt <= HW'(1);
            r_state   <= HIGH;
          end else if (r_lowCnt == LOW_LAST) begin
            r_lowCnt     <= LOW_FULL;
            frame_done   <= 1'b1;
            frame_pixels <= r_pixelCnt;
            partial_err  <= (r_bitCnt != 5'd0);
            r_bitCnt     <= '0;
            r_pixelCnt   <= '0;
            r_sreg       <= '0;
            r_state      <= IDLE;
          end else begin
            r_lowCnt <= r_lowCnt + 1'b1;
          end
        end

        default: r_state <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neo_data_decoder.sv
// Directed bench for neo_data_decoder: stimulus pushes expected events into a scoreboard
// queue, an independent monitor pops and compares whenever the decoder strobes.
module tb_neo_data_decoder;

  localparam int T0H      = 18;
  localparam int T1H      = 35;
  localparam int TBIT     = 62;
  localparam int LATCH    = 2520;

  logic        clock;
  logic        reset;
  logic        neo_data;
  logic [23:0] pixel_grb;
  logic        pixel_valid;
  logic [2:0]  pixel_num;
  logic        frame_done;
  logic [3:0]  frame_pixels;
  logic        glitch_err;
  logic        partial_err;
  logic        overrun_err;

  int checks = 0;
  int errors = 0;

  // strobes = {pixel_valid, frame_done, glitch_err, overrun_err, partial_err}
  typedef struct packed {
    logic [4:0]  strobes;
    logic [23:0] grb;
    logic [2:0]  num;
    logic [3:0]  fpix;
  } ev_t;

  ev_t expQ[$];
  ev_t act;
  ev_t expd;

  neo_data_decoder dut (
    .clock        (clock),
    .reset        (reset),
    .neo_data     (neo_data),
    .pixel_grb    (pixel_grb),
    .pixel_valid  (pixel_valid),
    .pixel_num    (pixel_num),
    .frame_done   (frame_done),
    .frame_pixels (frame_pixels),
    .glitch_err   (glitch_err),
    .partial_err  (partial_err),
    .overrun_err  (overrun_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive a level for n cycles; inputs change on the falling edge, away from DUT sampling.
  task automatic applyStimulus(input logic level, input int n);
    neo_data = level;
    repeat (n) @(negedge clock);
  endtask

  task automatic sendBit(input logic b);
    applyStimulus(1'b1, b ? T1H : T0H);
    applyStimulus(1'b0, TBIT - (b ? T1H : T0H));
  endtask

  task automatic sendBits(input logic [23:0] word, input int nbits);
    for (int i = 23; i > 23 - nbits; i--) sendBit(word[i]);
  endtask

  task automatic sendPixel(input logic [23:0] word);
    sendBits(word, 24);
  endtask

  task automatic pushPixel(input logic [23:0] grb, input logic [2:0] num);
    expQ.push_back('{strobes: 5'b10000, grb: grb, num: num, fpix: 4'd0});
  endtask

  task automatic pushFrame(input logic [3:0] n, input logic partial);
    expQ.push_back('{strobes: {4'b0100, partial}, grb: 24'd0, num: 3'd0, fpix: n});
  endtask

  task automatic pushGlitch();
    expQ.push_back('{strobes: 5'b00100, grb: 24'd0, num: 3'd0, fpix: 4'd0});
  endtask

  task automatic pushOverrun();
    expQ.push_back('{strobes: 5'b00010, grb: 24'd0, num: 3'd0, fpix: 4'd0});
  endtask

  task automatic checkDrained(input string name);
    checkOutput(name, 64'(expQ.size()), 64'd0);
  endtask

  // Monitor: any strobe pops the next expected event and compares the whole captured event.
  always @(negedge clock) begin
    if (reset === 1'b0 && (pixel_valid | frame_done | glitch_err | overrun_err | partial_err) !== 1'b0) begin
      act         = '0;
      act.strobes = {pixel_valid, frame_done, glitch_err, overrun_err, partial_err};
      if (pixel_valid) begin
        act.grb = pixel_grb;
        act.num = pixel_num;
      end
      if (frame_done) act.fpix = frame_pixels;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_event", 64'(act), 64'd0);
      end else begin
        expd = expQ.pop_front();
        checkOutput("event", 64'(act), 64'(expd));
      end
    end
  end

  initial begin
    logic [23:0] f2 [5];
    logic [23:0] f3 [6];
    logic [23:0] f6 [5];
    f2 = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF, 24'h000000};
    f3 = '{24'h123456, 24'hABCDEF, 24'h0F0F0F, 24'hF0F0F0, 24'h5A5AA5, 24'h777777};
    f6 = '{24'h010203, 24'h800001, 24'h55AA55, 24'hC0FFEE, 24'h7F7F80};

    neo_data = 1'b0;
    reset    = 1'b1;
    repeat (4) @(negedge clock);
    checkOutput("reset_state",
                64'({pixel_grb, pixel_valid, pixel_num, frame_done, frame_pixels,
                     glitch_err, partial_err, overrun_err}), 64'd0);
    reset = 1'b0;
    applyStimulus(1'b0, LATCH);

    $display("[TB] test 1: single pixel");
    pushPixel(24'h102030, 3'd0);
    sendPixel(24'h102030);
    pushFrame(4'd1, 1'b0);
    applyStimulus(1'b0, LATCH);
    checkDrained("t1_drained");

    $display("[TB] test 2: five-pixel frame");
    for (int i = 0; i < 5; i++) begin
      pushPixel(f2[i], 3'(i));
      sendPixel(f2[i]);
    end
    pushFrame(4'd5, 1'b0);
    applyStimulus(1'b0, LATCH);
    checkDrained("t2_drained");
    checkOutput("t2_hold_frame_pixels", 64'(frame_pixels), 64'd5);
    checkOutput("t2_hold_pixel_num", 64'(pixel_num), 64'd4);

    $display("[TB] test 3: six pixels overrun");
    for (int i = 0; i < 6; i++) begin
      if (i < 5) pushPixel(f3[i], 3'(i));
      else pushOverrun();
      sendPixel(f3[i]);
    end
    pushFrame(4'd5, 1'b0);
    applyStimulus(1'b0, LATCH);
    checkDrained("t3_drained");
    checkOutput("t3_hold_pixel_grb", 64'(pixel_grb), 64'h5A5AA5);

    $display("[TB] test 4a: short high pulse");
    sendBits(24'hA5A5A5, 10);
    pushGlitch();
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, LATCH);
    checkDrained("t4a_glitch_drained");
    pushPixel(24'hC3A501, 3'd0);
    sendPixel(24'hC3A501);
    pushFrame(4'd1, 1'b0);
    applyStimulus(1'b0, LATCH);
    checkDrained("t4a_drained");

    $display("[TB] test 4b: stuck-high pulse");
    sendBits(24'h3C3C3C, 5);
    pushGlitch();
    applyStimulus(1'b1, 70);
    applyStimulus(1'b0, LATCH);
    checkDrained("t4b_glitch_drained");
    pushPixel(24'h00FF81, 3'd0);
    sendPixel(24'h00FF81);
    pushFrame(4'd1, 1'b0);
    applyStimulus(1'b0, LATCH);
    checkDrained("t4b_drained");

    $display("[TB] test 5: partial pixel");
    sendBits(24'hFFF000, 12);
    pushFrame(4'd0, 1'b1);
    applyStimulus(1'b0, LATCH);
    checkDrained("t5_drained");

    $display("[TB] test 6: reset mid-frame");
    pushPixel(f6[0], 3'd0);
    sendPixel(f6[0]);
    pushPixel(f6[1], 3'd1);
    sendPixel(f6[1]);
    sendBits(f6[2], 10);
    checkDrained("t6_pre_reset_drained");
    neo_data = 1'b0;
    reset    = 1'b1;
    @(negedge clock);
    checkOutput("t6_reset_outputs",
                64'({pixel_grb, pixel_valid, pixel_num, frame_done, frame_pixels,
                     glitch_err, partial_err, overrun_err}), 64'd0);
    reset = 1'b0;
    applyStimulus(1'b0, LATCH);
    for (int i = 0; i < 5; i++) begin
      pushPixel(f6[i], 3'(i));
      sendPixel(f6[i]);
    end
    pushFrame(4'd5, 1'b0);
    applyStimulus(1'b0, LATCH);
    checkDrained("t6_drained");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
